// File: rtl/fft_pkg.sv
// Shared definitions for the IFFT-to-audio playback buffer.
//   DEFAULT_FRAME_LEN : samples per IFFT frame when the top is not overridden
//   DEFAULT_EXP_BIAS  : constant added to the summed block exponents
//   wr_state_t        : writer (Avalon-ST sink) states
//   bank_state_t      : ping-pong bank occupancy states
//   exp_t             : 7-bit signed exponent carried with each bank
//   frame_exp()       : combines forward and inverse block exponents plus bias
package fft_pkg;

  localparam int DEFAULT_FRAME_LEN = 8192;
  localparam int DEFAULT_EXP_BIAS  = 10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_FILL,
    W_STALL
  } wr_state_t;

  typedef enum logic [1:0] {
    B_FREE,
    B_FILLING,
    B_FULL
  } bank_state_t;

  typedef logic signed [6:0] exp_t;

  // Both exponents are 6-bit two's complement; the sum wraps to 7 bits.
  function automatic exp_t frame_exp(input logic [5:0] fwd_exp,
                                     input logic [5:0] inv_exp,
                                     input int         bias);
    int sum;
    sum = int'($signed(fwd_exp)) + int'($signed(inv_exp)) + bias;
    return exp_t'(sum);
  endfunction

endpackage

// File: rtl/exp_shift.sv
// Block-floating-point denormaliser: applies a signed exponent to a sample.
//   e : 7-bit signed exponent
//   x : 16-bit signed sample in
//   y : 16-bit scaled sample out
// e = 0 passes x; e in 1..12 shifts right arithmetically; e in -15..-1 keeps
// the sign bit and shifts the magnitude field left (overflow bits drop off);
// any other exponent is out of the useful range and yields silence.
module exp_shift (
  input  logic signed [6:0] e,
  input  logic [15:0]       x,
  output logic [15:0]       y
);

  logic [3:0] lsh;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the if-chain leaves it unassigned and infers a latch.
    lsh = 4'(-e);
    y   = '0;
    if (e == 7'sd0) begin
      y = x;
    end else if (e >= 7'sd1 && e <= 7'sd12) begin
      y = $signed(x) >>> e[3:0];
    end else if (e >= -7'sd15 && e <= -7'sd1) begin
      y = {x[15], x[14:0] << lsh};
    end
  end

endmodule

// File: rtl/fft_to_audio.sv
// Ping-pong buffer between an IFFT Avalon-ST source and an audio sample sink.
//   clk, reset_n         : single clock, synchronous active-low reset
//   sink_valid/ready     : Avalon-ST handshake (ready is registered)
//   sink_sop/eop         : frame delimiters
//   sink_real            : signed time-domain sample
//   sink_exp, in_exp     : inverse and forward block exponents of the frame
//   aud_req              : one-cycle request for the next audio sample
//   aud_data/aud_valid   : scaled sample, valid two cycles after aud_req
//   frame_err            : one-cycle pulse on any framing violation
//   underrun_cnt         : saturating count of requests answered with silence
module fft_to_audio
  import fft_pkg::*;
#(
  parameter int FRAME_LEN = DEFAULT_FRAME_LEN,
  parameter int EXP_BIAS  = DEFAULT_EXP_BIAS
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sink_valid,
  output logic        sink_ready,
  input  logic        sink_sop,
  input  logic        sink_eop,
  input  logic [15:0] sink_real,
  input  logic [5:0]  sink_exp,
  input  logic [5:0]  in_exp,
  input  logic        aud_req,
  output logic [15:0] aud_data,
  output logic        aud_valid,
  output logic        frame_err,
  output logic [15:0] underrun_cnt
);

  localparam int            AW       = $clog2(FRAME_LEN);
  localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);

  // Bank b occupies addresses {b, idx}.
  logic [15:0] mem [0:2*FRAME_LEN-1];

  wr_state_t   wst, wst_n;
  bank_state_t bank_st [2];
  bank_state_t bank_n  [2];
  exp_t        bank_exp   [2];
  exp_t        bank_exp_n [2];
  logic          wr_bank, wr_bank_n;
  logic [AW-1:0] wr_idx, wr_idx_n;
  logic          ready_n, err_n;
  logic          mem_we;
  logic [AW:0]   mem_waddr;
  logic          xfer, free_sel;
  exp_t          new_exp;

  logic          rd_bank, rd_bank_n;
  logic [AW-1:0] rd_idx, rd_idx_n;
  logic          rd_hit;

  // Read pipeline: stage 1 holds the RAM word, stage 2 the shifted output.
  logic        v1, hit1;
  logic [15:0] x1;
  exp_t        e1;
  logic [15:0] shifted;

  exp_shift u_shift (
    .e (e1),
    .x (x1),
    .y (shifted)
  );

  always_comb begin
    bank_n     = bank_st;
    bank_exp_n = bank_exp;
    wst_n      = wst;
    wr_bank_n  = wr_bank;
    wr_idx_n   = wr_idx;
    err_n      = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = {wr_bank, wr_idx};
    rd_bank_n  = rd_bank;
    rd_idx_n   = rd_idx;

    xfer    = sink_valid && sink_ready;
    new_exp = frame_exp(in_exp, sink_exp, EXP_BIAS);
    // With no bank FULL the reader waits on rd_bank, so fill that one; with
    // one FULL bank (always the reader's), fill the other.
    free_sel = (bank_st[rd_bank] == B_FREE) ? rd_bank : ~rd_bank;

    // Reader: consume one sample from the bank it is parked on.
    rd_hit = aud_req && (bank_st[rd_bank] == B_FULL);
    if (rd_hit) begin
      if (rd_idx == LAST_IDX) begin
        bank_n[rd_bank] = B_FREE;
        rd_bank_n       = ~rd_bank;
        rd_idx_n        = '0;
      end else begin
        rd_idx_n = rd_idx + 1'b1;
      end
    end

    // Writer. Reader updates above are visible through bank_n, so a bank
    // freed this cycle is seen when choosing the post-FULL state.
    unique case (wst)
      W_IDLE: begin
        if (xfer) begin
          if (!sink_sop || sink_eop) begin
            err_n = 1'b1;
          end else begin
            mem_we               = 1'b1;
            mem_waddr            = {free_sel, {AW{1'b0}}};
            bank_n[free_sel]     = B_FILLING;
            bank_exp_n[free_sel] = new_exp;
            wr_bank_n            = free_sel;
            wr_idx_n             = AW'(1);
            wst_n                = W_FILL;
          end
        end
      end
      W_FILL: begin
        if (xfer) begin
          mem_we = 1'b1;
          if (sink_sop) begin
            // Restart the same bank from the new frame's first beat.
            err_n               = 1'b1;
            mem_waddr           = {wr_bank, {AW{1'b0}}};
            bank_exp_n[wr_bank] = new_exp;
            wr_idx_n            = AW'(1);
          end else if (wr_idx == LAST_IDX) begin
            bank_n[wr_bank] = B_FULL;
            err_n           = !sink_eop;
            wst_n           = (bank_n[~wr_bank] == B_FREE) ? W_IDLE : W_STALL;
          end else if (sink_eop) begin
            err_n           = 1'b1;
            bank_n[wr_bank] = B_FREE;
            wst_n           = W_IDLE;
          end else begin
            wr_idx_n = wr_idx + 1'b1;
          end
        end
      end
      W_STALL: begin
        if (bank_n[0] == B_FREE || bank_n[1] == B_FREE) wst_n = W_IDLE;
      end
      default: wst_n = W_IDLE;
    endcase

    ready_n = (wst_n == W_FILL) ||
              (wst_n == W_IDLE && (bank_n[0] == B_FREE || bank_n[1] == B_FREE));
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values and the comb block above fully describes next state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wst          <= W_IDLE;
      bank_st[0]   <= B_FREE;
      bank_st[1]   <= B_FREE;
      bank_exp[0]  <= '0;
      bank_exp[1]  <= '0;
      wr_bank      <= 1'b0;
      wr_idx       <= '0;
      sink_ready   <= 1'b0;
      frame_err    <= 1'b0;
      rd_bank      <= 1'b0;
      rd_idx       <= '0;
      underrun_cnt <= '0;
      v1           <= 1'b0;
      hit1         <= 1'b0;
      aud_valid    <= 1'b0;
      aud_data     <= '0;
    end else begin
      wst        <= wst_n;
      bank_st    <= bank_n;
      bank_exp   <= bank_exp_n;
      wr_bank    <= wr_bank_n;
      wr_idx     <= wr_idx_n;
      sink_ready <= ready_n;
      frame_err  <= err_n;
      rd_bank    <= rd_bank_n;
      rd_idx     <= rd_idx_n;
      if (aud_req && !rd_hit && underrun_cnt != 16'hFFFF)
        underrun_cnt <= underrun_cnt + 16'd1;
      v1        <= aud_req;
      hit1      <= rd_hit;
      aud_valid <= v1;
      aud_data  <= (v1 && hit1) ? shifted : 16'h0000;
    end
  end

  // NOTE: the sample RAM and its read register carry no reset; bank state
  // alone decides what is valid, and resettable RAM would not map to block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= sink_real;
    if (rd_hit) begin
      x1 <= mem[{rd_bank, rd_idx}];
      e1 <= bank_exp[rd_bank];
    end
  end

endmodule

// File: tb/tb_fft_to_audio.sv
// Self-checking bench for fft_to_audio with FRAME_LEN=8, EXP_BIAS=10.
// Stimulus pushes expected audio samples (value and arrival cycle) into a
// scoreboard queue; an independent monitor pops and compares on aud_valid.
module tb_fft_to_audio;

  localparam int FL = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sink_valid, sink_ready, sink_sop, sink_eop;
  logic [15:0] sink_real;
  logic [5:0]  sink_exp, in_exp;
  logic        aud_req, aud_valid, frame_err;
  logic [15:0] aud_data, underrun_cnt;

  always #5 clk = ~clk;

  fft_to_audio #(.FRAME_LEN(FL), .EXP_BIAS(10)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sink_valid   (sink_valid),
    .sink_ready   (sink_ready),
    .sink_sop     (sink_sop),
    .sink_eop     (sink_eop),
    .sink_real    (sink_real),
    .sink_exp     (sink_exp),
    .in_exp       (in_exp),
    .aud_req      (aud_req),
    .aud_data     (aud_data),
    .aud_valid    (aud_valid),
    .frame_err    (frame_err),
    .underrun_cnt (underrun_cnt)
  );

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_item_t;

  exp_item_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int err_seen = 0;

  localparam logic [5:0] IE_M10 = 6'h36;  // -10

  logic [15:0] t2_in  [8] = '{16'h8000, 16'h4001, 16'h0100, 16'hFFFF,
                              16'h7FFF, 16'h0003, 16'hC000, 16'h1234};
  logic [15:0] t2_ep2 [8] = '{16'hE000, 16'h1000, 16'h0040, 16'hFFFF,
                              16'h1FFF, 16'h0000, 16'hF000, 16'h048D};
  logic [15:0] t2_em1 [8] = '{16'h8000, 16'h0002, 16'h0200, 16'hFFFE,
                              16'h7FFE, 16'h0006, 16'h8000, 16'h2468};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: counts frame_err pulses and checks every audio output.
  initial begin
    exp_item_t item;
    forever begin
      @(negedge clk);
      if (frame_err === 1'b1) err_seen++;
      if (aud_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_aud_valid", 32'(aud_valid), 32'd0);
        end else begin
          item = sb.pop_front();
          check("aud_data", 32'(aud_data), 32'(item.data));
          check("aud_latency", 32'(cyc), 32'(item.cyc));
        end
      end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
        item = sb.pop_front();
        check("aud_valid_missing", 32'(aud_valid), 32'd1);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_beat(input logic sop, input logic eop, input logic [15:0] d,
                           input logic [5:0] se, input logic [5:0] ie);
    int w = 0;
    while (sink_ready !== 1'b1 && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (sink_ready !== 1'b1) begin
      check("sink_ready_timeout", 32'(sink_ready), 32'd1);
    end else begin
      sink_valid = 1'b1;
      sink_sop   = sop;
      sink_eop   = eop;
      sink_real  = d;
      sink_exp   = se;
      in_exp     = ie;
      @(negedge clk);
      sink_valid = 1'b0;
      sink_sop   = 1'b0;
      sink_eop   = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [15:0] base);
    for (int i = 0; i < FL; i++) send_beat(i == 0, i == FL - 1, base + 16'(i), 6'd0, IE_M10);
  endtask

  task automatic req(input logic [15:0] d);
    aud_req = 1'b1;
    sb.push_back('{data: d, cyc: cyc + 2});
    @(negedge clk);
    aud_req = 1'b0;
  endtask

  initial begin
    int w;
    reset_n = 1'b0; sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    sink_real = '0; sink_exp = '0; in_exp = '0; aud_req = 1'b0;
    idle(3);
    check("rst_sink_ready", 32'(sink_ready), 32'd0);
    check("rst_aud_data", 32'(aud_data), 32'd0);
    check("rst_aud_valid", 32'(aud_valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_underrun_cnt", 32'(underrun_cnt), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(sink_ready), 32'd1);

    // Well-formed frame, e = 0.
    for (int i = 0; i < FL; i++) send_beat(i == 0, i == FL - 1, 16'(i + 1), 6'd0, IE_M10);
    for (int i = 0; i < FL; i++) req(16'(i + 1));
    idle(3);

    // Exponent shifts: e = 2, e = -1, e = 13.
    for (int i = 0; i < FL; i++) send_beat(i == 0, i == FL - 1, t2_in[i], 6'd2, IE_M10);
    for (int i = 0; i < FL; i++) req(t2_ep2[i]);
    for (int i = 0; i < FL; i++) send_beat(i == 0, i == FL - 1, t2_in[i], 6'h3F, IE_M10);
    for (int i = 0; i < FL; i++) req(t2_em1[i]);
    for (int i = 0; i < FL; i++) send_beat(i == 0, i == FL - 1, t2_in[i], 6'd13, IE_M10);
    for (int i = 0; i < FL; i++) req(16'h0000);
    idle(3);

    // Back-pressure: third frame stalls until the first bank is fully read.
    send_frame(16'h0010);
    send_frame(16'h0020);
    check("stall_after_16", 32'(sink_ready), 32'd0);
    fork
      send_frame(16'h0030);
      begin
        for (int k = 0; k < FL; k++) begin
          check("ready_during_stall", 32'(sink_ready), 32'd0);
          req(16'h0010 + 16'(k));
        end
        check("ready_after_free", 32'(sink_ready), 32'd1);
      end
    join
    for (int k = 0; k < FL; k++) req(16'h0020 + 16'(k));
    for (int k = 0; k < FL; k++) req(16'h0030 + 16'(k));
    idle(3);

    // Framing errors: early eop, stray sop, beat without sop in idle.
    for (int i = 0; i < 4; i++) send_beat(i == 0, i == 3, 16'h0E00 + 16'(i), 6'd0, IE_M10);
    idle(2);
    check("err_early_eop", 32'(err_seen), 32'd1);
    for (int i = 0; i < 5; i++) send_beat(i == 0, 1'b0, 16'h0E10 + 16'(i), 6'd0, IE_M10);
    send_frame(16'h0050);
    idle(2);
    check("err_stray_sop", 32'(err_seen), 32'd2);
    send_beat(1'b0, 1'b0, 16'h0EEE, 6'd0, IE_M10);
    idle(2);
    check("err_no_sop", 32'(err_seen), 32'd3);
    send_frame(16'h0060);
    for (int k = 0; k < FL; k++) req(16'h0050 + 16'(k));
    for (int k = 0; k < FL; k++) req(16'h0060 + 16'(k));
    idle(3);

    // Underrun counting and saturation.
    req(16'h0000);
    check("underrun_first", 32'(underrun_cnt), 32'd1);
    for (int k = 0; k < 65534; k++) req(16'h0000);
    check("underrun_reach_max", 32'(underrun_cnt), 32'h0000FFFF);
    req(16'h0000);
    check("underrun_saturated", 32'(underrun_cnt), 32'h0000FFFF);
    idle(3);

    // Reset mid-frame with a buffered frame and a read in flight.
    send_frame(16'h0A00);
    for (int i = 0; i < 3; i++) send_beat(i == 0, 1'b0, 16'h0B00 + 16'(i), 6'd0, IE_M10);
    sink_valid = 1'b1;
    sink_real  = 16'h0B03;
    aud_req    = 1'b1;  // read lands on the buffered frame; must be suppressed
    @(negedge clk);
    aud_req   = 1'b0;
    sink_real = 16'h0B04;
    reset_n   = 1'b0;
    @(negedge clk);
    sink_valid = 1'b0;
    check("midrst_sink_ready", 32'(sink_ready), 32'd0);
    check("midrst_aud_data", 32'(aud_data), 32'd0);
    check("midrst_aud_valid", 32'(aud_valid), 32'd0);
    check("midrst_frame_err", 32'(frame_err), 32'd0);
    check("midrst_underrun_cnt", 32'(underrun_cnt), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_midrst", 32'(sink_ready), 32'd1);
    send_frame(16'h0C00);
    for (int k = 0; k < FL; k++) req(16'h0C00 + 16'(k));

    w = 0;
    while (sb.size() != 0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    check("frame_err_total", 32'(err_seen), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
